// File: rtl/pcu_pkg.sv
// Shared constants and address helpers for the fetch PC unit.
// Functions take the widest address so any XLEN/FETCH_W instance can reuse them.
package pcu_pkg;

    localparam int INST_BYTES  = 4;
    localparam int MAX_XLEN    = 64;
    localparam int MAX_FETCH_W = 8;

    function automatic int off_bits(input int fetch_w);
        return $clog2(fetch_w);
    endfunction

    function automatic logic [MAX_XLEN-1:0] block_align(input logic [MAX_XLEN-1:0] addr,
                                                        input int fetch_w);
        logic [MAX_XLEN-1:0] blk_bytes;
        blk_bytes = MAX_XLEN'(fetch_w * INST_BYTES);
        return addr & ~(blk_bytes - MAX_XLEN'(1));
    endfunction

    // Lane i is live when it sits at or after the entry offset inside the block.
    function automatic logic [MAX_FETCH_W-1:0] lane_mask(input logic [MAX_XLEN-1:0] addr,
                                                         input int fetch_w);
        logic [MAX_XLEN-1:0] off_mask;
        int                  off;
        logic [MAX_FETCH_W-1:0] m;
        off_mask = (MAX_XLEN'(1) << off_bits(fetch_w)) - MAX_XLEN'(1);
        off      = int'((addr >> 2) & off_mask);
        m        = '0;
        for (int i = 0; i < MAX_FETCH_W; i++) begin
            m[i] = (i >= off) && (i < fetch_w);
        end
        return m;
    endfunction

endpackage

// File: rtl/pcu_redir_fifo.sv
// Small synchronous FIFO holding pending redirect targets.
// Clear wins over push and pop; full is a direct flop bit of the occupancy count.
module pcu_redir_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              clear,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = count[AW];
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pcu_fetch_gen.sv
// Program-counter unit: one fetch-block address plus lane mask per cycle,
// with a buffered redirect queue and an overriding flush port.
module pcu_fetch_gen
    import pcu_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter int              FETCH_W     = 2,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              REDIR_DEPTH = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ready_i,
    input  logic               redir_valid_i,
    input  logic [XLEN-1:0]    redir_addr_i,
    input  logic               flush_valid_i,
    input  logic [XLEN-1:0]    flush_addr_i,
    output logic               valid_o,
    output logic [XLEN-1:0]    inst_addr_o,
    output logic [FETCH_W-1:0] lane_mask_o,
    output logic               redir_full_o,
    output logic               redir_ovf_o
);

    localparam logic [XLEN-1:0] WORD_MASK   = ~XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] BLOCK_BYTES = XLEN'(FETCH_W * INST_BYTES);

    function automatic logic [XLEN-1:0] align_blk(input logic [XLEN-1:0] a);
        return XLEN'(block_align(MAX_XLEN'(a), FETCH_W));
    endfunction

    function automatic logic [FETCH_W-1:0] mask_of(input logic [XLEN-1:0] a);
        return FETCH_W'(lane_mask(MAX_XLEN'(a), FETCH_W));
    endfunction

    // Handshake: the fetch stage takes inst_addr_o/lane_mask_o on an edge where
    // valid_o and ready_i are both high; with ready_i low the address is held and
    // valid_o drops the next cycle. Flush ignores ready_i entirely.
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [FETCH_W-1:0] mask_q, mask_d;
    logic               valid_q, valid_d;
    logic               ovf_q;
    logic [XLEN-1:0]    fifo_head;
    logic               fifo_full, fifo_empty;
    logic               fifo_push, fifo_pop;

    assign fifo_push = redir_valid_i & ~flush_valid_i;
    assign fifo_pop  = ready_i & ~flush_valid_i & ~fifo_empty;

    pcu_redir_fifo #(
        .DATA_W (XLEN),
        .DEPTH  (REDIR_DEPTH)
    ) u_redir_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (redir_addr_i),
        .pop       (fifo_pop),
        .clear     (flush_valid_i),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        pc_d    = pc_q;
        mask_d  = mask_q;
        valid_d = 1'b0;
        if (flush_valid_i) begin
            pc_d    = flush_addr_i & WORD_MASK;
            mask_d  = mask_of(flush_addr_i);
            valid_d = 1'b1;
        end else if (!ready_i) begin
            valid_d = 1'b0;
        end else if (!fifo_empty) begin
            pc_d    = fifo_head & WORD_MASK;
            mask_d  = mask_of(fifo_head);
            valid_d = 1'b1;
        end else begin
            pc_d    = align_blk(pc_q) + BLOCK_BYTES;
            mask_d  = '1;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC & WORD_MASK;
            mask_q  <= mask_of(RESET_PC);
            valid_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            mask_q  <= mask_d;
            valid_q <= valid_d;
            // A flush discards the push, so it does not count as an overflow attempt.
            ovf_q   <= ovf_q | (redir_valid_i & ~flush_valid_i & fifo_full);
        end
    end

    assign inst_addr_o  = pc_q;
    assign lane_mask_o  = mask_q;
    assign valid_o      = valid_q;
    assign redir_full_o = fifo_full;
    assign redir_ovf_o  = ovf_q;

endmodule

// File: tb/tb_pcu_fetch_gen.sv
// Directed bench for pcu_fetch_gen: a 2-wide instance at boot 0 and a
// 4-wide instance booting mid-block at 0x1004.
module tb_pcu_fetch_gen;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ready;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic        flush_valid;
    logic [31:0] flush_addr;
    logic        valid;
    logic [31:0] inst_addr;
    logic [1:0]  lane_mask;
    logic        redir_full;
    logic        redir_ovf;

    logic        reset_n4;
    logic        ready4;
    logic        redir_valid4;
    logic [31:0] redir_addr4;
    logic        valid4;
    logic [31:0] inst_addr4;
    logic [3:0]  lane_mask4;
    logic        redir_full4;
    logic        redir_ovf4;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    pcu_fetch_gen #(.XLEN(32), .FETCH_W(2), .RESET_PC(32'h0), .REDIR_DEPTH(2)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ready_i       (ready),
        .redir_valid_i (redir_valid),
        .redir_addr_i  (redir_addr),
        .flush_valid_i (flush_valid),
        .flush_addr_i  (flush_addr),
        .valid_o       (valid),
        .inst_addr_o   (inst_addr),
        .lane_mask_o   (lane_mask),
        .redir_full_o  (redir_full),
        .redir_ovf_o   (redir_ovf)
    );

    pcu_fetch_gen #(.XLEN(32), .FETCH_W(4), .RESET_PC(32'h1004), .REDIR_DEPTH(2)) dut4 (
        .clk           (clk),
        .reset_n       (reset_n4),
        .ready_i       (ready4),
        .redir_valid_i (redir_valid4),
        .redir_addr_i  (redir_addr4),
        .flush_valid_i (1'b0),
        .flush_addr_i  (32'h0),
        .valid_o       (valid4),
        .inst_addr_o   (inst_addr4),
        .lane_mask_o   (lane_mask4),
        .redir_full_o  (redir_full4),
        .redir_ovf_o   (redir_ovf4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        ready       = 1'b1;
        redir_valid = 1'b0;
        redir_addr  = '0;
        flush_valid = 1'b0;
        flush_addr  = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (inst_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=%h", inst_addr, 32'h0); end
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL reset_valid got=%b exp=1", valid); end
        checks++; if (lane_mask !== 2'b11) begin failures++; $display("FAIL reset_mask got=%b exp=11", lane_mask); end
        checks++; if (redir_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", redir_full); end
        checks++; if (redir_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", redir_ovf); end
    endtask

    task automatic test_sequential();
        logic [31:0] e;
        do_reset();
        exp_q = '{32'h8, 32'h10, 32'h18, 32'h20};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            checks++; if (inst_addr !== e || valid !== 1'b1 || lane_mask !== 2'b11) begin
                failures++; $display("FAIL seq addr/valid/mask got=%h/%b/%b exp=%h/1/11", inst_addr, valid, lane_mask, e);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        step();
        step();
        redir_valid = 1'b1;
        redir_addr  = 32'h104;
        step();
        redir_valid = 1'b0;
        checks++; if (inst_addr !== 32'h18) begin failures++; $display("FAIL redir_no_bypass got=%h exp=%h", inst_addr, 32'h18); end
        step();
        checks++; if (inst_addr !== 32'h104 || lane_mask !== 2'b10 || valid !== 1'b1) begin
            failures++; $display("FAIL redir_target got=%h/%b/%b exp=104/10/1", inst_addr, lane_mask, valid);
        end
        step();
        checks++; if (inst_addr !== 32'h108 || lane_mask !== 2'b11) begin
            failures++; $display("FAIL redir_after got=%h/%b exp=108/11", inst_addr, lane_mask);
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (inst_addr !== 32'h10 || valid !== 1'b0) begin
                failures++; $display("FAIL stall_hold[%0d] got=%h/%b exp=10/0", i, inst_addr, valid);
            end
        end
        ready = 1'b1;
        step();
        checks++; if (inst_addr !== 32'h18 || valid !== 1'b1) begin
            failures++; $display("FAIL stall_release got=%h/%b exp=18/1", inst_addr, valid);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] e;
        do_reset();
        ready       = 1'b0;
        redir_valid = 1'b1;
        redir_addr  = 32'h200;
        step();
        checks++; if (redir_full !== 1'b0) begin failures++; $display("FAIL ovf_full_after1 got=%b exp=0", redir_full); end
        redir_addr = 32'h300;
        step();
        checks++; if (redir_full !== 1'b1 || redir_ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_full_after2 full/ovf got=%b/%b exp=1/0", redir_full, redir_ovf);
        end
        redir_addr = 32'h400;
        step();
        checks++; if (redir_ovf !== 1'b1 || redir_full !== 1'b1) begin
            failures++; $display("FAIL ovf_sticky full/ovf got=%b/%b exp=1/1", redir_full, redir_ovf);
        end
        checks++; if (inst_addr !== 32'h0 || valid !== 1'b0) begin
            failures++; $display("FAIL ovf_stall got=%h/%b exp=0/0", inst_addr, valid);
        end
        redir_valid = 1'b0;
        ready       = 1'b1;
        exp_q = '{32'h200, 32'h300, 32'h308};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            step();
            checks++; if (inst_addr !== e || valid !== 1'b1) begin
                failures++; $display("FAIL ovf_drain got=%h/%b exp=%h/1", inst_addr, valid, e);
            end
        end
        checks++; if (redir_full !== 1'b0 || redir_ovf !== 1'b1) begin
            failures++; $display("FAIL ovf_after_drain full/ovf got=%b/%b exp=0/1", redir_full, redir_ovf);
        end
    endtask

    task automatic test_flush();
        do_reset();
        ready       = 1'b0;
        redir_valid = 1'b1;
        redir_addr  = 32'h600;
        step();
        redir_addr = 32'h700;
        step();
        flush_valid = 1'b1;
        flush_addr  = 32'h8000;
        redir_addr  = 32'h500;
        step();
        flush_valid = 1'b0;
        redir_valid = 1'b0;
        checks++; if (inst_addr !== 32'h8000 || valid !== 1'b1 || lane_mask !== 2'b11) begin
            failures++; $display("FAIL flush_target got=%h/%b/%b exp=8000/1/11", inst_addr, valid, lane_mask);
        end
        checks++; if (redir_full !== 1'b0) begin failures++; $display("FAIL flush_clears_full got=%b exp=0", redir_full); end
        ready = 1'b1;
        step();
        checks++; if (inst_addr !== 32'h8008) begin failures++; $display("FAIL flush_next1 got=%h exp=8008", inst_addr); end
        step();
        checks++; if (inst_addr !== 32'h8010) begin failures++; $display("FAIL flush_next2 got=%h exp=8010", inst_addr); end
        flush_valid = 1'b1;
        flush_addr  = 32'h8006;
        step();
        flush_valid = 1'b0;
        checks++; if (inst_addr !== 32'h8004 || lane_mask !== 2'b10) begin
            failures++; $display("FAIL flush_midblock got=%h/%b exp=8004/10", inst_addr, lane_mask);
        end
        step();
        checks++; if (inst_addr !== 32'h8008 || lane_mask !== 2'b11) begin
            failures++; $display("FAIL flush_midblock_next got=%h/%b exp=8008/11", inst_addr, lane_mask);
        end
    endtask

    task automatic test_reset_wide();
        reset_n4     = 1'b0;
        ready4       = 1'b0;
        redir_valid4 = 1'b0;
        redir_addr4  = '0;
        step();
        reset_n4 = 1'b1;
        checks++; if (inst_addr4 !== 32'h1004 || lane_mask4 !== 4'b1110 || valid4 !== 1'b1) begin
            failures++; $display("FAIL w4_reset got=%h/%b/%b exp=1004/1110/1", inst_addr4, lane_mask4, valid4);
        end
        redir_valid4 = 1'b1;
        redir_addr4  = 32'h2000;
        step();
        redir_valid4 = 1'b0;
        checks++; if (redir_full4 !== 1'b0 || inst_addr4 !== 32'h1004) begin
            failures++; $display("FAIL w4_queued full/addr got=%b/%h exp=0/1004", redir_full4, inst_addr4);
        end
        #2;
        reset_n4 = 1'b0;
        #1;
        checks++; if (inst_addr4 !== 32'h1004 || lane_mask4 !== 4'b1110 || valid4 !== 1'b1 || redir_ovf4 !== 1'b0) begin
            failures++; $display("FAIL w4_async_reset got=%h/%b/%b exp=1004/1110/1", inst_addr4, lane_mask4, valid4);
        end
        step();
        reset_n4 = 1'b1;
        ready4   = 1'b1;
        step();
        checks++; if (inst_addr4 !== 32'h1010 || lane_mask4 !== 4'b1111 || valid4 !== 1'b1) begin
            failures++; $display("FAIL w4_after_reset got=%h/%b/%b exp=1010/1111/1", inst_addr4, lane_mask4, valid4);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        ready        = 1'b1;
        redir_valid  = 1'b0;
        redir_addr   = '0;
        flush_valid  = 1'b0;
        flush_addr   = '0;
        reset_n4     = 1'b0;
        ready4       = 1'b0;
        redir_valid4 = 1'b0;
        redir_addr4  = '0;
        step();
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_overflow();
        test_flush();
        test_reset_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcu_fetch_gen.md
# pcu_fetch_gen

Parametrised program-counter unit for the in-order front end. Each cycle it presents one fetch-block address and a per-lane valid mask to the instruction fetch stage, for a configurable fetch width. Redirect targets from the backend are buffered in a redirect queue. A separate high-priority flush port overrides everything and empties the queue. It replaces the fixed two-way PC unit so that one block serves 1-, 2- and 4-wide front ends.

## Interface
- XLEN, 32, address width
- FETCH_W, 2, instructions per fetch block; power of two, 1..8
- RESET_PC, 32'h0, boot address; low log2(FETCH_W)+2 bits need not be zero
- REDIR_DEPTH, 2, redirect queue entries; power of two ≥ 2

Ports:
- clk  in  1  clock
- reset_n  in  1  reset: asynchronous, active-low
- ready_i  in  1  fetch stage accepts current address this cycle
- redir_valid_i  in  1  push redirect target
- redir_addr_i  in  XLEN  redirect target; bits [1:0] ignored
- flush_valid_i  in  1  pipeline flush (exception/mispredict recovery)
- flush_addr_i  in  XLEN  flush target; bits [1:0] ignored
- valid_o  out  1  inst_addr_o/lane_mask_o valid
- inst_addr_o  out  XLEN  fetch address; bits [1:0] always 0
- lane_mask_o  out  FETCH_W  bit i set = lane i holds a live instruction
- redir_full_o  out  1  redirect queue full
- redir_ovf_o  out  1  sticky: a push was attempted while full

## Operation
- Block offset OFF = inst_addr_o[log2(FETCH_W)+1:2]. lane_mask_o bit i = (i ≥ OFF). Lanes below the entry point of a mid-block target are masked.
- Sequential next PC = (inst_addr_o with offset and [1:0] cleared) + FETCH_W*4, wrapping modulo 2^XLEN. The next mask is all ones.
- Next-state priority, evaluated each cycle:
  1. flush_valid_i: inst_addr_o ← flush_addr_i & ~3, valid_o ← 1, queue cleared, redir_valid_i that cycle discarded. This applies regardless of ready_i.
  2. ~ready_i: hold inst_addr_o, valid_o ← 0.
  3. ready_i and queue non-empty: pop head; inst_addr_o ← head, valid_o ← 1.
  4. ready_i and queue empty: inst_addr_o ← sequential next PC, valid_o ← 1.
- Push: redir_valid_i & ~full & ~flush_valid_i writes the tail.
  - A push while full is dropped and sets redir_ovf_o; it is cleared only by reset.
  - A push and a pop in the same cycle are both performed; count is unchanged.
  - A push while full is still rejected even if a pop occurs that cycle.
- No bypass: a target pushed in cycle N is never consumed in cycle N.
- Queue occupancy counter width is log2(REDIR_DEPTH)+1. Read and write pointers wrap modulo REDIR_DEPTH.

## Timing
- Reset values:
  - inst_addr_o = RESET_PC & ~3
  - valid_o = 1
  - lane_mask_o = mask of RESET_PC
  - redir_full_o = 0, redir_ovf_o = 0
  - queue empty, pointers 0
- All outputs are registered. lane_mask_o is registered alongside inst_addr_o and is never combinationally derived from the inputs.
- Redirect latency: push on the edge ending cycle N; earliest appearance on inst_addr_o is cycle N+2 (pop at end of N+1, when ready_i is high in N+1).
- Flush latency: flush asserted in cycle N; inst_addr_o = target in cycle N+1.
- redir_full_o reflects occupancy after the current edge and is updated in the same cycle as the count.
- A reset asserted mid-operation immediately forces all reset values and discards queued redirects.

## Structure
- Package pcu_pkg holds:
  - INST_BYTES = 4
  - function off_bits(FETCH_W)
  - function block_align(addr, FETCH_W)
  - function lane_mask(addr, FETCH_W)
- Sub-module pcu_redir_fifo is a synchronous FIFO (DATA_W, DEPTH) with push, pop, clear, full and empty.
  - Clear has priority over push and pop.
  - The top level holds the PC/valid/mask registers and the priority mux.

## Test plan
All scenarios use FETCH_W=2, RESET_PC=0, REDIR_DEPTH=2 unless stated.
- Reset then ready_i=1 steady → inst_addr_o 0x0, 0x8, 0x10, 0x18; mask 2'b11; valid_o=1 throughout.
- Push 0x104 at cycle 2 → inst_addr_o=0x104 with mask 2'b10 at cycle 4, then 0x108 with mask 2'b11.
- ready_i=0 for 3 cycles at addr 0x10 → valid_o=0 and addr held at 0x10; ready_i=1 → next address 0x18.
- With ready_i=0, push 0x200, 0x300, then 0x400 → redir_full_o=1 after the second push; third push dropped and redir_ovf_o=1. Release ready → 0x200, 0x300, 0x308.
- Two targets queued, then flush_valid_i with addr 0x8000 and concurrent push 0x500 while ready_i=0 → inst_addr_o=0x8000, valid_o=1 next cycle; queue empty; next addresses 0x8008, 0x8010.
- Reset asserted with 1 queued entry, FETCH_W=4, RESET_PC=0x1004 → inst_addr_o=0x1004, mask 4'b1110; queue empty; then 0x1010 with mask 4'b1111.
